// File: rtl/spi_shift.sv
// -----------------------------------------------------------------------------
// spi_shift -- SPI data shift engine
//
// Sits behind the SPI clock generator. Uses the generator's pos_edge/neg_edge
// strobes to shift a transmit word out on s_out and to collect s_in into
// rx_data. `last` feeds the generator's last_clk and `tip` its enable, so SCLK
// stops right after the programmed character length and parks low.
//
// Optional feature macro: SPI_SHIFT_LSB_EN
//   defined   : the lsb input selects LSB-first (1) or MSB-first (0) order
//   undefined : MSB-first only, lsb is ignored
//
// Ports:
//   clk_in      system clock, rising edge
//   rst         asynchronous, active-high reset
//   wr_en       load wr_data into the TX register (ignored while tip=1)
//   wr_data     transmit word
//   go          start a transfer (ignored while tip=1)
//   len         character length, 0 means DATA_W bits
//   lsb         bit order select (see macro above)
//   tx_negedge  1: launch s_out on neg_edge, 0: on pos_edge
//   rx_negedge  1: sample s_in on neg_edge, 0: on pos_edge
//   pos_edge    clock generator rising-edge strobe
//   neg_edge    clock generator falling-edge strobe
//   s_clk       clock generator SCLK level
//   s_in        serial data in (MISO)
//   s_out       serial data out (MOSI), holds last bit after a transfer
//   tip         transfer in progress
//   last        both bit counters are zero (combinational)
//   rx_data     received word
//   done        one-cycle pulse at the end of a transfer
//
// Request semantics: wr_en and go are single-cycle requests with no
// backpressure. They take effect only in a cycle where tip=0; anything
// presented while tip=1 is dropped. When both arrive together, the transfer
// starts with the wr_data being written.
// -----------------------------------------------------------------------------
module spi_shift #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              go,
    input  logic [LEN_W-1:0]  len,
    input  logic              lsb,
    input  logic              tx_negedge,
    input  logic              rx_negedge,
    input  logic              pos_edge,
    input  logic              neg_edge,
    input  logic              s_clk,
    input  logic              s_in,
    output logic              s_out,
    output logic              tip,
    output logic              last,
    output logic [DATA_W-1:0] rx_data,
    output logic              done
);
    // Counters hold 0..DATA_W, so they need one bit more than len.
    localparam int CNT_W = LEN_W + 1;

    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              s_out_q, s_out_d;
    logic              tip_q, tip_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  n_go;
    logic [DATA_W-1:0] tx_src;
    logic              tx_edge;
    logic              rx_edge;
    logic [LEN_W-1:0]  start_idx;
    logic [LEN_W-1:0]  tx_idx;
    logic [LEN_W-1:0]  rx_idx;

    assign n_go    = (len == '0) ? CNT_W'(DATA_W) : CNT_W'(len);
    assign tx_src  = wr_en ? wr_data : tx_q;
    assign tx_edge = tx_negedge ? neg_edge : pos_edge;
    assign rx_edge = rx_negedge ? neg_edge : pos_edge;
    assign last    = (tx_cnt_q == '0) && (rx_cnt_q == '0);

    // Bit number b = N - cnt. MSB first uses index N-1-b, which is cnt-1;
    // LSB first uses index b directly and so needs N kept for the transfer.
`ifdef SPI_SHIFT_LSB_EN
    logic             lsb_q, lsb_d;
    logic [CNT_W-1:0] n_q, n_d;

    always_comb begin
        start_idx = lsb ? '0 : LEN_W'(n_go - CNT_W'(1));
        tx_idx    = lsb_q ? LEN_W'(n_q - tx_cnt_q) : LEN_W'(tx_cnt_q - CNT_W'(1));
        rx_idx    = lsb_q ? LEN_W'(n_q - rx_cnt_q) : LEN_W'(rx_cnt_q - CNT_W'(1));
    end
`else
    logic unused_lsb;
    assign unused_lsb = lsb;
    assign start_idx  = LEN_W'(n_go - CNT_W'(1));
    assign tx_idx     = LEN_W'(tx_cnt_q - CNT_W'(1));
    assign rx_idx     = LEN_W'(rx_cnt_q - CNT_W'(1));
`endif

    always_comb begin
        tx_d     = tx_q;
        rx_d     = rx_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        s_out_d  = s_out_q;
        tip_d    = tip_q;
        done_d   = 1'b0;
`ifdef SPI_SHIFT_LSB_EN
        lsb_d    = lsb_q;
        n_d      = n_q;
`endif
        if (!tip_q) begin
            if (wr_en) begin
                tx_d = wr_data;
            end
            if (go) begin
                tip_d    = 1'b1;
                rx_cnt_d = n_go;
                rx_d     = '0;
`ifdef SPI_SHIFT_LSB_EN
                lsb_d    = lsb;
                n_d      = n_go;
`endif
                // Launching on neg_edge means the first bit must already be
                // on the line before the first rising SCLK edge.
                if (tx_negedge) begin
                    s_out_d  = tx_src[start_idx];
                    tx_cnt_d = n_go - CNT_W'(1);
                end else begin
                    tx_cnt_d = n_go;
                end
            end
        end else begin
            if (tx_edge && (tx_cnt_q != '0)) begin
                s_out_d  = tx_q[tx_idx];
                tx_cnt_d = tx_cnt_q - CNT_W'(1);
            end
            if (rx_edge && (rx_cnt_q != '0)) begin
                rx_d[rx_idx] = s_in;
                rx_cnt_d     = rx_cnt_q - CNT_W'(1);
            end
            // Wait for SCLK to be parked low with no falling edge pending,
            // so the generator has finished before enable drops.
            if (last && !s_clk && !neg_edge) begin
                tip_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tx_q     <= '0;
            rx_q     <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            s_out_q  <= 1'b0;
            tip_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef SPI_SHIFT_LSB_EN
            lsb_q    <= 1'b0;
            n_q      <= '0;
`endif
        end else begin
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            s_out_q  <= s_out_d;
            tip_q    <= tip_d;
            done_q   <= done_d;
`ifdef SPI_SHIFT_LSB_EN
            lsb_q    <= lsb_d;
            n_q      <= n_d;
`endif
        end
    end

    assign s_out   = s_out_q;
    assign tip     = tip_q;
    assign rx_data = rx_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spi_shift.sv
// -----------------------------------------------------------------------------
// tb_spi_shift -- self-checking bench for spi_shift
//
// The bench plays the SPI clock generator (divider, strobes, SCLK parking on
// last) and a slave that samples MOSI on the edge opposite the launch edge.
// Expected MOSI bits and expected received words are pushed when a transfer
// is started and popped when the slave samples / when done pulses.
// Follows SPI_SHIFT_LSB_EN for its bit-order model.
// -----------------------------------------------------------------------------
module tb_spi_shift;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 5;

    logic              clk_in = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              go;
    logic [LEN_W-1:0]  len;
    logic              lsb;
    logic              tx_negedge;
    logic              rx_negedge;
    logic              pos_edge;
    logic              neg_edge;
    logic              s_clk;
    logic              s_in;
    logic              s_out;
    logic              tip;
    logic              last;
    logic [DATA_W-1:0] rx_data;
    logic              done;

    spi_shift #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .go         (go),
        .len        (len),
        .lsb        (lsb),
        .tx_negedge (tx_negedge),
        .rx_negedge (rx_negedge),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .s_clk      (s_clk),
        .s_in       (s_in),
        .s_out      (s_out),
        .tip        (tip),
        .last       (last),
        .rx_data    (rx_data),
        .done       (done)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0] exp_q[$];      // expected rx_data per transfer
    logic              exp_bit_q[$];  // expected MOSI bits in wire order
    logic [DATA_W-1:0] tx_model;

    int n_checks = 0;
    int n_fail   = 0;

    int   div;
    int   div_cnt;
    int   cur_n;
    int   tx_bits;
    int   rx_edges;
    int   done_cnt;
    logic loop_en;
    logic s_in_fix;
    logic prev_tip, prev_s_clk, prev_neg, prev_last;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clk_in cycle: observe the DUT #1 after the edge, then act as
    // clock generator and slave for the coming cycle.
    task automatic step();
        @(posedge clk_in);
        #1;
        if (pos_edge) s_clk = 1'b1;
        if (neg_edge) s_clk = 1'b0;
        pos_edge = 1'b0;
        neg_edge = 1'b0;

        if (done) begin
            done_cnt++;
            if (exp_q.size() > 0) begin
                check("rx_data", rx_data, exp_q.pop_front());
                check("tip_low_at_done", {31'd0, tip}, 32'd0);
            end
        end
        if (prev_tip && !tip)
            check("tip_fall_sclk_low", {30'd0, prev_s_clk, prev_neg}, 32'd0);
        if (tip && last && !prev_last)
            check("last_after_rx_edges", rx_edges, cur_n);

        if (tip) begin
            if (div_cnt >= div) begin
                div_cnt = 0;
                if (s_clk) neg_edge = 1'b1;
                else if (!last) pos_edge = 1'b1;
            end else begin
                div_cnt++;
            end
        end else begin
            div_cnt = 0;
        end

        s_in = loop_en ? s_out : s_in_fix;
        if (tx_negedge ? pos_edge : neg_edge) begin
            if (exp_bit_q.size() > 0)
                check("mosi_bit", {31'd0, s_out}, {31'd0, exp_bit_q.pop_front()});
            tx_bits++;
        end
        if (rx_negedge ? neg_edge : pos_edge) rx_edges++;

        prev_tip   = tip;
        prev_s_clk = s_clk;
        prev_neg   = neg_edge;
        prev_last  = last;
    endtask

    task automatic reset_mid();
        exp_q.delete();
        exp_bit_q.delete();
        rst = 1'b1;
        #1;
        check("abort_s_out", {31'd0, s_out}, 32'd0);
        check("abort_tip", {31'd0, tip}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_rx_data", rx_data, 32'd0);
        check("abort_last", {31'd0, last}, 32'd1);
        pos_edge  = 1'b0;
        neg_edge  = 1'b0;
        s_clk     = 1'b0;
        div_cnt   = 0;
        prev_tip  = 1'b0;
        prev_last = 1'b1;
        tx_model  = '0;
        step();
        step();
        rst = 1'b0;
        repeat (12) step();
        check("no_done_after_abort", done_cnt, 0);
    endtask

    task automatic do_xfer(input logic [DATA_W-1:0] data, input bit wr,
                           input logic [LEN_W-1:0] l, input bit lsb_v,
                           input bit txn, input bit rxn, input int dv,
                           input bit loop_v, input int inject_cyc,
                           input int rst_bit, input bit b2b);
        int                n;
        int                cyc;
        bit                aborted;
        bit                lsb_eff;
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] mask;

        n    = (l == '0) ? DATA_W : int'(l);
        word = wr ? data : tx_model;
        if (wr) tx_model = data;
`ifdef SPI_SHIFT_LSB_EN
        lsb_eff = lsb_v;
`else
        lsb_eff = 1'b0;
`endif
        mask = (n == DATA_W) ? '1 : ((32'd1 << n) - 32'd1);
        for (int i = 0; i < n; i++)
            exp_bit_q.push_back(word[lsb_eff ? i : n - 1 - i]);
        exp_q.push_back(loop_v ? (word & mask) : mask);

        cur_n    = n;
        tx_bits  = 0;
        rx_edges = 0;
        done_cnt = 0;
        div      = dv;
        loop_en  = loop_v;
        s_in_fix = 1'b1;
        aborted  = 1'b0;

        len        = l;
        lsb        = lsb_v;
        tx_negedge = txn;
        rx_negedge = rxn;
        wr_en      = wr;
        wr_data    = data;
        go         = 1'b1;
        step();
        go      = 1'b0;
        wr_en   = 1'b0;
        wr_data = $urandom;
        check("tip_after_go", {31'd0, tip}, 32'd1);

        cyc = 0;
        while (done_cnt == 0 && cyc < 2000 && !aborted) begin
            if (cyc == inject_cyc) begin
                go      = 1'b1;
                wr_en   = 1'b1;
                wr_data = 32'h0000_00FF;
            end
            step();
            if (cyc == inject_cyc) begin
                check("tip_hold_on_inject", {31'd0, tip}, 32'd1);
                go    = 1'b0;
                wr_en = 1'b0;
            end
            cyc++;
            if (rst_bit >= 0 && tx_bits == rst_bit) begin
                reset_mid();
                aborted = 1'b1;
            end
        end

        if (!aborted) begin
            check("done_seen", done_cnt, 1);
            check("mosi_bit_count", tx_bits, n);
            if (!b2b) begin
                repeat (2) step();
                check("done_single_pulse", done_cnt, 1);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = '0;
        go         = 1'b0;
        len        = '0;
        lsb        = 1'b0;
        tx_negedge = 1'b0;
        rx_negedge = 1'b0;
        pos_edge   = 1'b0;
        neg_edge   = 1'b0;
        s_clk      = 1'b0;
        s_in       = 1'b0;
        tx_model   = '0;
        div        = 0;
        div_cnt    = 0;
        cur_n      = 0;
        tx_bits    = 0;
        rx_edges   = 0;
        done_cnt   = 0;
        loop_en    = 1'b1;
        s_in_fix   = 1'b0;
        prev_tip   = 1'b0;
        prev_s_clk = 1'b0;
        prev_neg   = 1'b0;
        prev_last  = 1'b1;

        repeat (2) @(posedge clk_in);
        #1;
        check("reset_s_out", {31'd0, s_out}, 32'd0);
        check("reset_tip", {31'd0, tip}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rx_data", rx_data, 32'd0);
        check("reset_last", {31'd0, last}, 32'd1);
        rst = 1'b0;
        step();

        // MSB first, 8 bits, launch on neg, sample on pos, loopback
        do_xfer(32'h0000_00A5, 1, 5'd8, 0, 1, 0, 1, 1, -1, -1, 0);
        // 32 bits, launch on pos, sample on neg, divider 0
        do_xfer(32'h8000_0001, 1, 5'd0, 1, 0, 1, 0, 1, -1, -1, 0);
        // MISO tied high, 4 bits; SCLK is high when last rises
        do_xfer($urandom, 1, 5'd4, 0, 1, 0, 2, 0, -1, -1, 0);
        // go + wr_en 0xFF mid-transfer are dropped; the TX register keeps 0x3C
        do_xfer(32'h0000_003C, 1, 5'd8, 0, 1, 0, 1, 1, 5, -1, 0);
        do_xfer(32'h0, 0, 5'd8, 0, 1, 1, 1, 1, -1, -1, 0);
        // reset during bit 3, then a normal transfer
        do_xfer(32'h0000_00C3, 1, 5'd8, 0, 1, 0, 1, 1, -1, 3, 0);
        do_xfer(32'h0000_005A, 1, 5'd8, 0, 1, 0, 1, 1, -1, -1, 0);
        // divider 0, 2 bits, both bit orders
        do_xfer(32'h0000_0001, 1, 5'd2, 0, 1, 0, 0, 1, -1, -1, 0);
        do_xfer(32'h0000_0001, 1, 5'd2, 1, 1, 0, 0, 1, -1, -1, 0);

        // random transfers, partly back to back
        for (int k = 0; k < 8; k++) begin
            int mode;
            mode = $urandom_range(0, 2);
            do_xfer($urandom, 1, LEN_W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    (mode != 1), (mode != 0), $urandom_range(0, 3), 1, -1, -1, (k % 2 == 0));
        end
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
